// File: rtl/bam_pkg.sv
// rtl/bam_pkg.sv - bam_ctrl opcodes, instruction field positions and FSM states
package bam_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
  localparam logic [OP_W-1:0] OP_LDI   = 3'b001;
  localparam logic [OP_W-1:0] OP_ALUST = 3'b010;
  localparam logic [OP_W-1:0] OP_BEQZ  = 3'b011;

  // Least significant bit of each instruction field.
  localparam int OP_LSB     = 29;
  localparam int FUNC_LSB   = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RAMDIR_LSB = 11;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_e;

endpackage

// File: rtl/bam_ctrl_dec.sv
// rtl/bam_ctrl_dec.sv - combinational opcode to strobe/flag decode
module bam_ctrl_dec
  import bam_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output logic            reg_write,
  output logic            ram_write,
  output logic            is_beqz,
  output logic            is_illegal
);

  always_comb begin
    reg_write  = 1'b0;
    ram_write  = 1'b0;
    is_beqz    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_LDI:   reg_write  = 1'b1;
      OP_ALUST: ram_write  = 1'b1;
      OP_BEQZ:  is_beqz    = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bam_ctrl.sv
// rtl/bam_ctrl.sv - bam datapath sequencer: IDLE->DECODE->EXEC->DONE per instruction
// Optional BAM_CTRL_PERF_EN adds retired/taken-branch counters.
module bam_ctrl
  import bam_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 3,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic              bamZf,
  output logic [ADDR_W-1:0] bamRA1,
  output logic [ADDR_W-1:0] bamRA2,
  output logic [SEL_W-1:0]  bamSel,
  output logic [ADDR_W-1:0] bamDir,
  output logic              bamwr,
  output logic [ADDR_W-1:0] bamDirB,
  output logic [DATA_W-1:0] bamDi,
  output logic              bamRegWrite,
  output logic              done,
  output logic              illegal,
  output logic              br_taken,
`ifdef BAM_CTRL_PERF_EN
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_taken,
`endif
  output logic [IMM_W-1:0]  br_offset
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        zf_q, zf_d;

  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] rs, rt, ramdir;
  logic [SEL_W-1:0]  func;
  logic [IMM_W-1:0]  imm;
  logic dec_reg_write, dec_ram_write, dec_beqz, dec_illegal;
  logic in_read, in_exec, in_done;

  assign op     = instr_q[OP_LSB +: OP_W];
  assign func   = instr_q[FUNC_LSB +: SEL_W];
  assign rs     = instr_q[RS_LSB +: ADDR_W];
  assign rt     = instr_q[RT_LSB +: ADDR_W];
  assign ramdir = instr_q[RAMDIR_LSB +: ADDR_W];
  assign imm    = instr_q[IMM_LSB +: IMM_W];

  bam_ctrl_dec u_dec (
    .op         (op),
    .reg_write  (dec_reg_write),
    .ram_write  (dec_ram_write),
    .is_beqz    (dec_beqz),
    .is_illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      zf_q    <= zf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    zf_d    = zf_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        // The zero flag only matters at the end of a BEQZ execute cycle.
        if (dec_beqz) zf_d = bamZf;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_read = (state_q == DECODE) || (state_q == EXEC);
  assign in_exec = (state_q == EXEC);
  assign in_done = (state_q == DONE);

  assign instr_ready = (state_q == IDLE);
  assign bamRA1      = in_read ? rs   : '0;
  assign bamRA2      = in_read ? rt   : '0;
  assign bamSel      = in_read ? func : '0;
  assign bamwr       = in_exec & dec_ram_write;
  assign bamDir      = bamwr ? ramdir : '0;
  assign bamRegWrite = in_exec & dec_reg_write;
  assign bamDirB     = bamRegWrite ? rs : '0;
  assign bamDi       = bamRegWrite ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : '0;
  assign done        = in_done;
  assign illegal     = in_done & dec_illegal;
  assign br_taken    = in_done & dec_beqz & zf_q;
  assign br_offset   = (in_done & dec_beqz) ? imm : '0;

`ifdef BAM_CTRL_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_taken_q, perf_taken_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= '0;
      perf_taken_q   <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_taken_q   <= perf_taken_d;
    end
  end

  always_comb begin
    perf_retired_d = perf_retired_q;
    perf_taken_d   = perf_taken_q;
    if (done)     perf_retired_d = perf_retired_q + 32'd1;
    if (br_taken) perf_taken_d   = perf_taken_q + 32'd1;
  end

  assign perf_retired = perf_retired_q;
  assign perf_taken   = perf_taken_q;
`endif

endmodule
